// File: rtl/m_pile_tracker_pkg.sv
// Shared op and FSM encodings for the pile tracker and its move-history LIFO.
package m_pile_tracker_pkg;

  typedef enum logic [1:0] {
    OP_DROP  = 2'b00,
    OP_UNDO  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/m_pile_tracker_history.sv
// m_pile_history: synchronous LIFO of column indices; clear wins over push, push over pop.
module m_pile_history #(
  parameter int DEPTH = 42,
  parameter int WIDTH = 3,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, top_idx;

  assign o_empty = (ptr_q == '0);
  assign o_full  = (ptr_q == PTR_MAX);
  assign top_idx = ptr_q - 1'b1;
  assign o_top   = o_empty ? '0 : mem_q[top_idx];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (i_clear) begin
      ptr_d = '0;
    end else if (i_push && !o_full) begin
      mem_d[ptr_q] = i_data;
      ptr_d        = ptr_q + 1'b1;
    end else if (i_pop && !o_empty) begin
      ptr_d = top_idx;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Storage needs no reset: entries above the pointer are never read.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/m_pile_tracker.sv
// Per-column pile heights for a drop-grid game, served by an IDLE/UPDATE/DONE handshake.
// Define PILE_UNDO_EN to build the move-history LIFO that makes UNDO functional.
module m_pile_tracker
  import m_pile_tracker_pkg::*;
#(
  parameter int COL_COUNT = 7,
  parameter int ROW_COUNT = 6,
  localparam int COL_W    = $clog2(COL_COUNT),
  localparam int HEIGHT_W = $clog2(ROW_COUNT + 1),
  localparam int CNT_W    = $clog2(COL_COUNT * ROW_COUNT + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_req,
  input  logic [1:0]                    i_op,
  input  logic [COL_W-1:0]              i_col,
  output logic                          o_ready,
  output logic                          o_done,
  output logic                          o_ok,
  output logic [COL_W-1:0]              o_col,
  output logic [HEIGHT_W-1:0]           o_row,
  output logic [COL_COUNT*HEIGHT_W-1:0] o_heights,
  output logic [CNT_W-1:0]              o_count,
  output logic                          o_full,
  output logic [1:0]                    o_dbg_state
);

  localparam logic [HEIGHT_W-1:0] ROW_MAX = HEIGHT_W'(ROW_COUNT);
  localparam logic [COL_W:0]      COL_LIM = (COL_W + 1)'(COL_COUNT);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [COL_W-1:0]      col_q, col_d, res_col_q, res_col_d;
  logic                  ok_q, ok_d, full_q, full_d;
  logic [HEIGHT_W-1:0]   row_q, row_d, sel_h;
  logic [HEIGHT_W-1:0]   heights_q [COL_COUNT];
  logic [HEIGHT_W-1:0]   heights_d [COL_COUNT];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  col_in_range;
  logic                  hist_push, hist_pop, hist_clear, hist_empty;
  logic [COL_W-1:0]      hist_top;

`ifdef PILE_UNDO_EN
  logic unused_hist_full;
  m_pile_history #(
    .DEPTH (COL_COUNT * ROW_COUNT),
    .WIDTH (COL_W)
  ) u_history (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (hist_push),
    .i_pop   (hist_pop),
    .i_clear (hist_clear),
    .i_data  (col_q),
    .o_top   (hist_top),
    .o_empty (hist_empty),
    .o_full  (unused_hist_full)
  );
`else
  // Without history every UNDO sees an empty stack and is rejected.
  logic unused_hist;
  assign hist_top    = '0;
  assign hist_empty  = 1'b1;
  assign unused_hist = ^{hist_push, hist_pop, hist_clear};
`endif

  assign col_in_range = ({1'b0, col_q} < COL_LIM);
  assign sel_h        = col_in_range ? heights_q[col_q] : '0;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; i_req only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_req) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_done  = (state_q == ST_DONE);
  end

  always_comb begin
    op_d       = op_q;
    col_d      = col_q;
    ok_d       = ok_q;
    res_col_d  = res_col_q;
    row_d      = row_q;
    heights_d  = heights_q;
    count_d    = count_q;
    hist_push  = 1'b0;
    hist_pop   = 1'b0;
    hist_clear = 1'b0;
    if (state_q == ST_IDLE && i_req) begin
      op_d  = op_e'(i_op);
      col_d = i_col;
    end
    if (state_q == ST_UPDATE) begin
      // Reject by default: o_col reports the requested column, o_row is held.
      ok_d      = 1'b0;
      res_col_d = col_q;
      case (op_q)
        OP_DROP: if (col_in_range && sel_h != ROW_MAX) begin
          ok_d             = 1'b1;
          row_d            = sel_h;
          heights_d[col_q] = sel_h + 1'b1;
          count_d          = count_q + 1'b1;
          hist_push        = 1'b1;
        end
        OP_UNDO: if (!hist_empty) begin
          ok_d                = 1'b1;
          res_col_d           = hist_top;
          row_d               = heights_q[hist_top] - 1'b1;
          heights_d[hist_top] = heights_q[hist_top] - 1'b1;
          count_d             = count_q - 1'b1;
          hist_pop            = 1'b1;
        end
        OP_CLEAR: begin
          ok_d       = 1'b1;
          res_col_d  = '0;
          row_d      = '0;
          count_d    = '0;
          hist_clear = 1'b1;
          for (int c = 0; c < COL_COUNT; c++) heights_d[c] = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    full_d = 1'b1;
    for (int c = 0; c < COL_COUNT; c++) begin
      if (heights_d[c] != ROW_MAX) full_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= OP_DROP;
      col_q     <= '0;
      ok_q      <= 1'b0;
      res_col_q <= '0;
      row_q     <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      for (int c = 0; c < COL_COUNT; c++) heights_q[c] <= '0;
    end else begin
      op_q      <= op_d;
      col_q     <= col_d;
      ok_q      <= ok_d;
      res_col_q <= res_col_d;
      row_q     <= row_d;
      count_q   <= count_d;
      full_q    <= full_d;
      heights_q <= heights_d;
    end
  end

  always_comb begin
    o_heights = '0;
    for (int c = 0; c < COL_COUNT; c++) o_heights[c*HEIGHT_W +: HEIGHT_W] = heights_q[c];
  end

  assign o_ok        = ok_q;
  assign o_col       = res_col_q;
  assign o_row       = row_q;
  assign o_count     = count_q;
  assign o_full      = full_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_m_pile_tracker.sv
// Bench for m_pile_tracker: vector table, corner sequences, and random ops against a pile model.
module tb_m_pile_tracker;

`ifdef PILE_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  // Clock/reset block
  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [2:0]  i_col = 3'd0;
  logic        o_ready, o_done, o_ok, o_full;
  logic [2:0]  o_col, o_row;
  logic [20:0] o_heights;
  logic [5:0]  o_count;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  m_pile_tracker dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_op        (i_op),
    .i_col       (i_col),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_ok        (o_ok),
    .o_col       (o_col),
    .o_row       (o_row),
    .o_heights   (o_heights),
    .o_count     (o_count),
    .o_full      (o_full),
    .o_dbg_state (o_dbg_state)
  );

  // Scoreboard counters and the pile model
  int n_cmp = 0;
  int n_fail = 0;
  int mh [7];
  int mhist [$];
  int m_ok, m_col, m_row;
  int got_ok, got_col, got_row;

  typedef struct {
    int op;
    int col;
    int ok;
    int ocol;
    int row;
    int cnt;
  } vec_t;
  vec_t vt [19];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 7; c++) mh[c] = 0;
    mhist.delete();
    m_ok = 0; m_col = 0; m_row = 0;
  endfunction

  function automatic void model_step(input int op, input int col);
    int c;
    case (op)
      0: begin
        m_col = col;
        if (col >= 7) m_ok = 0;
        else if (mh[col] == 6) m_ok = 0;
        else begin
          m_ok = 1; m_row = mh[col]; mh[col]++; mhist.push_back(col);
        end
      end
      1: begin
        if (UNDO_EN && mhist.size() > 0) begin
          c = mhist.pop_back();
          mh[c]--; m_ok = 1; m_col = c; m_row = mh[c];
        end else begin
          m_ok = 0; m_col = col;
        end
      end
      2: begin
        for (int k = 0; k < 7; k++) mh[k] = 0;
        mhist.delete();
        m_ok = 1; m_col = 0; m_row = 0;
      end
      default: begin
        m_ok = 0; m_col = col;
      end
    endcase
  endfunction

  task automatic check_all(input string tag);
    int sum;
    int allf;
    sum = 0; allf = 1;
    check({tag, "_ok"},  int'(o_ok),  m_ok);
    check({tag, "_col"}, int'(o_col), m_col);
    check({tag, "_row"}, int'(o_row), m_row);
    for (int c = 0; c < 7; c++) begin
      check($sformatf("%s_h%0d", tag, c), int'(o_heights[3*c +: 3]), mh[c]);
      sum += mh[c];
      if (mh[c] != 6) allf = 0;
    end
    check({tag, "_count"}, int'(o_count), sum);
    check({tag, "_full"},  int'(o_full),  allf);
  endtask

  // Driver: one full request/complete handshake with cycle-exact timing checks
  task automatic do_op(input int op, input int col, input string tag);
    check({tag, "_ready_before"}, int'(o_ready), 1);
    i_req = 1'b1; i_op = 2'(op); i_col = 3'(col);
    @(negedge clk);
    i_req = 1'b0;
    check({tag, "_ready_busy"}, int'(o_ready), 0);
    check({tag, "_done_early"}, int'(o_done), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(o_done), 1);
    got_ok = int'(o_ok); got_col = int'(o_col); got_row = int'(o_row);
    @(negedge clk);
    check({tag, "_done_width"}, int'(o_done), 0);
    check({tag, "_ready_back"}, int'(o_ready), 1);
    model_step(op, col);
    check_all(tag);
  endtask

  int ready_cnt, done_cnt, r;

  initial begin
    // Expected results after reset, written out by hand
    vt[0]  = '{0, 3, 1, 3, 0, 1};
    vt[1]  = '{0, 3, 1, 3, 1, 2};
    vt[2]  = '{0, 3, 1, 3, 2, 3};
    vt[3]  = '{0, 3, 1, 3, 3, 4};
    for (int i = 0; i < 6; i++) vt[4+i] = '{0, 0, 1, 0, i, 5 + i};
    vt[10] = '{0, 0, 0, 0, 5, 10};
    vt[11] = '{0, 7, 0, 7, 5, 10};
    vt[12] = '{2, 0, 1, 0, 0, 0};
    vt[13] = '{0, 2, 1, 2, 0, 1};
    vt[14] = '{0, 5, 1, 5, 0, 2};
    if (UNDO_EN) begin
      vt[15] = '{1, 0, 1, 5, 0, 1};
      vt[16] = '{1, 0, 1, 2, 0, 0};
      vt[17] = '{1, 0, 0, 0, 0, 0};
      vt[18] = '{3, 4, 0, 4, 0, 0};
    end else begin
      vt[15] = '{1, 0, 0, 0, 0, 2};
      vt[16] = '{1, 0, 0, 0, 0, 2};
      vt[17] = '{1, 0, 0, 0, 0, 2};
      vt[18] = '{3, 4, 0, 4, 0, 2};
    end

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    check("rst_ready", int'(o_ready), 1);
    check("rst_done",  int'(o_done), 0);
    check_all("rst");

    for (int i = 0; i < 19; i++) begin
      do_op(vt[i].op, vt[i].col, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tok", i),  got_ok,  vt[i].ok);
      check($sformatf("vec%0d_tcol", i), got_col, vt[i].ocol);
      check($sformatf("vec%0d_trow", i), got_row, vt[i].row);
      check($sformatf("vec%0d_tcnt", i), int'(o_count), vt[i].cnt);
    end

    // Fill the whole board round-robin, then clear it
    do_op(2, 0, "pre_fill_clear");
    for (int i = 0; i < 42; i++) do_op(0, i % 7, $sformatf("fill%0d", i));
    check("fill_full",  int'(o_full), 1);
    check("fill_count", int'(o_count), 42);
    do_op(0, 4, "fill_overflow");
    check("fill_overflow_ok", got_ok, 0);
    do_op(2, 0, "fill_clear");
    check("clear_ok",      got_ok, 1);
    check("clear_full",    int'(o_full), 0);
    check("clear_count",   int'(o_count), 0);
    check("clear_heights", int'(o_heights), 0);

    // Held request: one accept every three cycles
    ready_cnt = 0; done_cnt = 0;
    i_req = 1'b1; i_op = 2'b00; i_col = 3'd1;
    for (int k = 0; k < 12; k++) begin
      ready_cnt += int'(o_ready);
      done_cnt  += int'(o_done);
      @(negedge clk);
    end
    i_req = 1'b0;
    check("hold_ready_cnt", ready_cnt, 4);
    check("hold_done_cnt",  done_cnt, 4);
    for (int k = 0; k < 4; k++) model_step(0, 1);
    check_all("hold");

    // Reset while a DROP is in UPDATE
    i_req = 1'b1; i_op = 2'b00; i_col = 3'd4;
    @(negedge clk);
    i_req = 1'b0;
    check("midrst_busy", int'(o_ready), 0);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    model_reset();
    check("midrst_done",  int'(o_done), 0);
    check("midrst_ready", int'(o_ready), 1);
    check_all("midrst");
    @(negedge clk);
    check("midrst_no_done", int'(o_done), 0);

    // Random traffic against the model
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      do_op(0, $urandom_range(0, 7), $sformatf("rnd%0d", i));
      else if (r < 85) do_op(1, $urandom_range(0, 7), $sformatf("rnd%0d", i));
      else if (r < 90) do_op(2, $urandom_range(0, 7), $sformatf("rnd%0d", i));
      else             do_op(3, $urandom_range(0, 7), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
